// File: rtl/fetch_pkg.sv
// Shared widths, the NOP encoding and the bubble bundle driven by the
// fetch stage whenever it has no real instruction to present.
package fetch_pkg;

    localparam int PC_W   = 12;
    localparam int INSN_W = 32;

    localparam logic [INSN_W-1:0] NOP_INSN = 32'h00000013;

    typedef struct packed {
        logic              valid;
        logic [INSN_W-1:0] insn;
        logic [PC_W-1:0]   pc;
        logic [PC_W-1:0]   pc_plus;
    } fetch_out_t;

    localparam fetch_out_t FETCH_BUBBLE = '{
        valid:   1'b0,
        insn:    NOP_INSN,
        pc:      '0,
        pc_plus: '0
    };

endpackage

// File: rtl/fetch_hold_buf.sv
// One-entry capture/release register that parks the in-flight instruction
// while the stage is stalled; clear drops it on a redirect.
module fetch_hold_buf #(
    parameter int PC_W   = fetch_pkg::PC_W,
    parameter int INSN_W = fetch_pkg::INSN_W
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              i_capture,
    input  logic              i_release,
    input  logic              i_clear,
    input  logic [INSN_W-1:0] i_insn,
    input  logic [PC_W-1:0]   i_pc,
    output logic              o_valid,
    output logic [INSN_W-1:0] o_insn,
    output logic [PC_W-1:0]   o_pc
);

    logic              valid_q, valid_d;
    logic [INSN_W-1:0] insn_q, insn_d;
    logic [PC_W-1:0]   pc_q, pc_d;

    always_comb begin
        valid_d = valid_q;
        insn_d  = insn_q;
        pc_d    = pc_q;
        if (i_clear) begin
            valid_d = 1'b0;
        end else if (i_capture) begin
            valid_d = 1'b1;
            insn_d  = i_insn;
            pc_d    = i_pc;
        end else if (i_release) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            valid_q <= 1'b0;
            insn_q  <= '0;
            pc_q    <= '0;
        end else begin
            valid_q <= valid_d;
            insn_q  <= insn_d;
            pc_q    <= pc_d;
        end
    end

    assign o_valid = valid_q;
    assign o_insn  = insn_q;
    assign o_pc    = pc_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC, 1-cycle ROM request, stall hold buffer and
// redirect squash. Define FETCH_PERF_CNT_EN to add fetch/squash counters.
module fetch_stage #(
    parameter int              PC_W     = fetch_pkg::PC_W,
    parameter int              INSN_W   = fetch_pkg::INSN_W,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              i_stall,
    input  logic              i_redirect,
    input  logic [PC_W-1:0]   i_redirect_PC,
    output logic [PC_W-1:0]   o_imem_addr,
    output logic              o_imem_en,
    input  logic [INSN_W-1:0] i_imem_data,
    output logic [INSN_W-1:0] o_insn,
    output logic [PC_W-1:0]   o_PC,
    output logic [PC_W-1:0]   o_PC_plus,
    output logic              o_valid
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]       o_fetch_count,
    output logic [31:0]       o_squash_count
`endif
);

    import fetch_pkg::*;

    logic              issue;
    logic [PC_W-1:0]   pc_q, pc_d;
    logic              req_valid_q, req_valid_d;
    logic [PC_W-1:0]   req_pc_q, req_pc_d;

    logic              hold_valid;
    logic [INSN_W-1:0] hold_insn;
    logic [PC_W-1:0]   hold_pc;
    logic              hold_capture;

    assign issue       = !i_stall && !i_redirect;
    assign o_imem_addr = pc_q;
    assign o_imem_en   = issue;

    // Nothing is issued while stalled, so the single hold entry cannot overflow.
    assign hold_capture = i_stall && req_valid_q && !hold_valid;

    always_comb begin
        pc_d        = pc_q;
        req_valid_d = 1'b0;
        req_pc_d    = req_pc_q;
        if (i_redirect) begin
            pc_d = i_redirect_PC;
        end else if (issue) begin
            pc_d        = pc_q + PC_W'(1);
            req_valid_d = 1'b1;
            req_pc_d    = pc_q;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            pc_q        <= RESET_PC;
            req_valid_q <= 1'b0;
            req_pc_q    <= '0;
        end else begin
            pc_q        <= pc_d;
            req_valid_q <= req_valid_d;
            req_pc_q    <= req_pc_d;
        end
    end

    fetch_hold_buf #(
        .PC_W   (PC_W),
        .INSN_W (INSN_W)
    ) u_hold (
        .clock     (clock),
        .reset     (reset),
        .i_capture (hold_capture),
        .i_release (!i_stall),
        .i_clear   (i_redirect),
        .i_insn    (i_imem_data),
        .i_pc      (req_pc_q),
        .o_valid   (hold_valid),
        .o_insn    (hold_insn),
        .o_pc      (hold_pc)
    );

    always_comb begin
        o_valid   = FETCH_BUBBLE.valid;
        o_insn    = INSN_W'(FETCH_BUBBLE.insn);
        o_PC      = PC_W'(FETCH_BUBBLE.pc);
        o_PC_plus = PC_W'(FETCH_BUBBLE.pc_plus);
        if (i_redirect) begin
            o_valid = 1'b0;
        end else if (hold_valid) begin
            o_valid   = 1'b1;
            o_insn    = hold_insn;
            o_PC      = hold_pc;
            o_PC_plus = hold_pc + PC_W'(1);
        end else if (req_valid_q) begin
            o_valid   = 1'b1;
            o_insn    = i_imem_data;
            o_PC      = req_pc_q;
            o_PC_plus = req_pc_q + PC_W'(1);
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_count_q, fetch_count_d;
    logic [31:0] squash_count_q, squash_count_d;

    always_comb begin
        fetch_count_d  = fetch_count_q;
        squash_count_d = squash_count_q;
        if (o_valid && !i_stall) begin
            fetch_count_d = fetch_count_q + 32'd1;
        end
        if (i_redirect && (hold_valid || req_valid_q)) begin
            squash_count_d = squash_count_q + 32'd1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            fetch_count_q  <= '0;
            squash_count_q <= '0;
        end else begin
            fetch_count_q  <= fetch_count_d;
            squash_count_q <= squash_count_d;
        end
    end

    assign o_fetch_count  = fetch_count_q;
    assign o_squash_count = squash_count_q;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed-vector scoreboard bench for fetch_stage; ROM[n] = n.
module tb_fetch_stage;

    import fetch_pkg::*;

    logic        clock = 1'b0;
    logic        reset;
    logic        i_stall;
    logic        i_redirect;
    logic [11:0] i_redirect_PC;
    logic [11:0] o_imem_addr;
    logic        o_imem_en;
    logic [31:0] i_imem_data;
    logic [31:0] o_insn;
    logic [11:0] o_PC;
    logic [11:0] o_PC_plus;
    logic        o_valid;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] o_fetch_count;
    logic [31:0] o_squash_count;
`endif

    always #5 clock = ~clock;

    fetch_stage dut (
        .clock         (clock),
        .reset         (reset),
        .i_stall       (i_stall),
        .i_redirect    (i_redirect),
        .i_redirect_PC (i_redirect_PC),
        .o_imem_addr   (o_imem_addr),
        .o_imem_en     (o_imem_en),
        .i_imem_data   (i_imem_data),
        .o_insn        (o_insn),
        .o_PC          (o_PC),
        .o_PC_plus     (o_PC_plus),
        .o_valid       (o_valid)
`ifdef FETCH_PERF_CNT_EN
        ,
        .o_fetch_count (o_fetch_count),
        .o_squash_count(o_squash_count)
`endif
    );

    // Synchronous ROM, 1-cycle latency, contents ROM[n] = n
    always @(posedge clock) begin
        if (o_imem_en) i_imem_data <= {20'h0, o_imem_addr};
    end

    typedef struct {
        int          id;
        logic        valid;
        logic [11:0] pc;
        logic [11:0] addr;
        logic        en;
    } exp_t;

    exp_t sb[$];
    int   vectors = 0;
    int   miscompares = 0;
    int   vid = 0;

    exp_t        cur;
    logic [31:0] e_insn;
    logic [11:0] e_pc;
    logic [11:0] e_plus;

    always @(negedge clock) begin
        if (sb.size() > 0) begin
            cur    = sb.pop_front();
            e_insn = cur.valid ? {20'h0, cur.pc} : NOP_INSN;
            e_pc   = cur.valid ? cur.pc : 12'h000;
            e_plus = cur.valid ? cur.pc + 12'd1 : 12'h000;
            vectors++;
            if (o_valid !== cur.valid || o_insn !== e_insn ||
                o_PC !== e_pc || o_PC_plus !== e_plus ||
                o_imem_addr !== cur.addr || o_imem_en !== cur.en) begin
                miscompares++;
                $display("FAIL vec%0d: got v=%b insn=%h pc=%h plus=%h addr=%h en=%b; want v=%b insn=%h pc=%h plus=%h addr=%h en=%b",
                         cur.id, o_valid, o_insn, o_PC, o_PC_plus, o_imem_addr, o_imem_en,
                         cur.valid, e_insn, e_pc, e_plus, cur.addr, cur.en);
            end
        end
    end

    task automatic step(input logic r, input logic s, input logic d,
                        input logic [11:0] t, input logic ev,
                        input logic [11:0] epc, input logic [11:0] ea);
        exp_t e;
        reset         = r;
        i_stall       = s;
        i_redirect    = d;
        i_redirect_PC = t;
        e.id    = vid;
        e.valid = ev;
        e.pc    = epc;
        e.addr  = ea;
        e.en    = !s && !d;
        sb.push_back(e);
        vid++;
        @(posedge clock);
        #1;
    endtask

    initial begin
        reset         = 1'b1;
        i_stall       = 1'b0;
        i_redirect    = 1'b0;
        i_redirect_PC = 12'h000;
        repeat (2) @(posedge clock);
        #1;
        //    rst  stl  red  target  v   pc      addr
        step(1'b1, 1'b0, 1'b0, 12'h000, 1'b0, 12'h000, 12'h000);
        step(1'b0, 1'b0, 1'b0, 12'h000, 1'b0, 12'h000, 12'h000);
        step(1'b0, 1'b0, 1'b0, 12'h000, 1'b1, 12'h000, 12'h001);
        step(1'b0, 1'b0, 1'b0, 12'h000, 1'b1, 12'h001, 12'h002);
        step(1'b0, 1'b0, 1'b0, 12'h000, 1'b1, 12'h002, 12'h003);
        step(1'b0, 1'b0, 1'b0, 12'h000, 1'b1, 12'h003, 12'h004);
        step(1'b0, 1'b0, 1'b0, 12'h000, 1'b1, 12'h004, 12'h005);
        // stall 3 cycles with PC 5 at the output
        step(1'b0, 1'b1, 1'b0, 12'h000, 1'b1, 12'h005, 12'h006);
        step(1'b0, 1'b1, 1'b0, 12'h000, 1'b1, 12'h005, 12'h006);
        step(1'b0, 1'b1, 1'b0, 12'h000, 1'b1, 12'h005, 12'h006);
        step(1'b0, 1'b0, 1'b0, 12'h000, 1'b1, 12'h005, 12'h006);
        step(1'b0, 1'b0, 1'b0, 12'h000, 1'b1, 12'h006, 12'h007);
        // redirect to 0x100 while PC 7 is at the output
        step(1'b0, 1'b0, 1'b1, 12'h100, 1'b0, 12'h000, 12'h008);
        step(1'b0, 1'b0, 1'b0, 12'h000, 1'b0, 12'h000, 12'h100);
        step(1'b0, 1'b0, 1'b0, 12'h000, 1'b1, 12'h100, 12'h101);
        // fill hold, then redirect+stall together
        step(1'b0, 1'b1, 1'b0, 12'h000, 1'b1, 12'h101, 12'h102);
        step(1'b0, 1'b1, 1'b1, 12'h200, 1'b0, 12'h000, 12'h102);
        step(1'b0, 1'b1, 1'b0, 12'h000, 1'b0, 12'h000, 12'h200);
        step(1'b0, 1'b0, 1'b0, 12'h000, 1'b0, 12'h000, 12'h200);
        step(1'b0, 1'b0, 1'b0, 12'h000, 1'b1, 12'h200, 12'h201);
        // PC wrap at 0xFFF
        step(1'b0, 1'b0, 1'b1, 12'hFFE, 1'b0, 12'h000, 12'h202);
        step(1'b0, 1'b0, 1'b0, 12'h000, 1'b0, 12'h000, 12'hFFE);
        step(1'b0, 1'b0, 1'b0, 12'h000, 1'b1, 12'hFFE, 12'hFFF);
        step(1'b0, 1'b0, 1'b0, 12'h000, 1'b1, 12'hFFF, 12'h000);
        step(1'b0, 1'b0, 1'b0, 12'h000, 1'b1, 12'h000, 12'h001);
        // reset mid-stall with hold full
        step(1'b0, 1'b1, 1'b0, 12'h000, 1'b1, 12'h001, 12'h002);
        step(1'b0, 1'b1, 1'b0, 12'h000, 1'b1, 12'h001, 12'h002);
        step(1'b1, 1'b1, 1'b0, 12'h000, 1'b1, 12'h001, 12'h002);
        step(1'b0, 1'b1, 1'b0, 12'h000, 1'b0, 12'h000, 12'h000);
`ifdef FETCH_PERF_CNT_EN
        vectors++;
        if (o_fetch_count !== 32'd0 || o_squash_count !== 32'd0) begin
            miscompares++;
            $display("FAIL perf_after_reset: got fetch=%0d squash=%0d; want 0 0",
                     o_fetch_count, o_squash_count);
        end
`endif
        step(1'b0, 1'b0, 1'b0, 12'h000, 1'b0, 12'h000, 12'h000);
        step(1'b0, 1'b0, 1'b0, 12'h000, 1'b1, 12'h000, 12'h001);
        step(1'b0, 1'b0, 1'b0, 12'h000, 1'b1, 12'h001, 12'h002);
        for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clock);
        if (sb.size() > 0) begin
            miscompares++;
            $display("FAIL drain: %0d vectors left unchecked; want 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
